axi_lite_cfg_master: RTL and testbench
======================================

Name: axi_lite_cfg_master

Overview:
- Single-outstanding AXI4-Lite master that converts a simple command/response interface into AXI4-Lite register transactions.
- Sits between the dataplane configuration sequencer (or PS-side command FIFO) and axi_lite_slave; it sequences every register access to the slave.
- One transaction in flight; write and read channels never active simultaneously.

Parameters:
ADDR_W, 32, address width of cmd_addr and m_awaddr/m_araddr
DATA_W, 32, data width (32 only; WSTRB width = DATA_W/8)
TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with AXI_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  register byte address
cmd_wdata  input  DATA_W  write data
cmd_wstrb  input  DATA_W/8  write byte strobes
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_resp  output  2  BRESP/RRESP of transaction
m_awaddr, m_awprot  output  ADDR_W, 3  write address; prot fixed 3'b000
m_awvalid / m_awready  output / input  1  AW handshake
m_wdata, m_wstrb  output  DATA_W, DATA_W/8  write data
m_wvalid / m_wready  output / input  1  W handshake
m_bvalid / m_bready  input / output  1  B handshake
m_bresp  input  2  write response
m_araddr, m_arprot  output  ADDR_W, 3  read address; prot fixed 3'b000
m_arvalid / m_arready  output / input  1  AR handshake
m_rvalid / m_rready  input / output  1  R handshake
m_rdata, m_rresp  input  DATA_W, 2  read data/response

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all valid/ready outputs 0, rsp_valid 0, rsp_rdata/rsp_resp 0, address/data outputs 0. Reset mid-transaction drops it with no response; slave is reset alongside.
- FSM: IDLE, WR (AW+W), WR_B, RD_A, RD_R, RSP.
- IDLE: cmd_ready=1. On cmd handshake, latch addr/wdata/wstrb into output regs; go to WR if cmd_write, else RD_A. AW/AR valid rises the cycle after acceptance.
- WR: m_awvalid and m_wvalid asserted together. Each drops independently on its own handshake (aw_done/w_done flags); either order or same cycle accepted. Both done -> WR_B. Valids never drop before handshake; payload stable while valid.
- WR_B: m_bready=1; on m_bvalid capture m_bresp -> RSP.
- RD_A: m_arvalid=1 until m_arready -> RD_R.
- RD_R: m_rready=1; on m_rvalid capture m_rdata, m_rresp -> RSP.
- RSP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_resp held until next RSP; -> IDLE. cmd_ready=0 in every state except IDLE.
- Minimum latency with zero-wait slave: cmd accept N, AW/W handshake N+1, B N+2, rsp_valid N+3. Read identical.
- Back-to-back: next cmd accepted earliest the cycle after rsp_valid.
- Non-OKAY responses passed through unchanged; no retry.

Optional Feature:
- AXI_TIMEOUT_EN defined: counter clears on cmd accept, increments in WR/WR_B/RD_A/RD_R; reaching TIMEOUT_CYC forces RSP with rsp_resp=2'b10 (SLVERR), rsp_rdata=0, all master valid/ready deasserted. A late B/R beat from the slave in IDLE is ignored.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write addr 0x04 data 0xDEADBEEF strb 0xF, zero-wait slave -> one AW/W handshake, rsp_valid 3 cycles after accept, rsp_resp=00, rsp_rdata=0.
- Read back 0x04 -> single AR/R handshake, rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Slave holds AWREADY low 5 cycles while WREADY=1 -> W completes first, AW held stable; exactly one B, one rsp_valid.
- Four back-to-back commands (W,R,W,R) with cmd_valid held high -> cmd_ready only in IDLE, four rsp pulses in order, data matches.
- Assert rst_n=0 during WR_B -> next cycle all outputs 0, no rsp_valid; subsequent write/read of 0x08 succeeds.
- AXI_TIMEOUT_EN, TIMEOUT_CYC=16, slave never asserts ARREADY -> rsp_valid at cycle 16 after accept, rsp_resp=10, m_arvalid low.

Source files
------------

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master: single-outstanding cmd/rsp to AXI4-Lite master bridge.
// Optional watchdog enabled by defining AXI_TIMEOUT_EN.
module axi_lite_cfg_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]          resp_q, resp_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                accept, aw_hs, w_hs, b_hs, r_hs, timeout;
  assign accept = cmd_valid & cmd_ready;
  assign aw_hs  = m_awvalid & m_awready;
  assign w_hs   = m_wvalid & m_wready;
  assign b_hs   = m_bvalid & m_bready;
  assign r_hs   = m_rvalid & m_rready;
`ifdef AXI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy;
  assign busy = state_q inside {WR, WR_B, RD_A, RD_R};
  // Timer holds the number of busy cycles already elapsed, so firing at
  // TIMEOUT_CYC-2 puts rsp_valid TIMEOUT_CYC cycles after acceptance.
  assign timeout = busy && (timer_q == TW'(TIMEOUT_CYC - 2));
  always_comb timer_d = accept ? '0 : busy ? timer_q + TW'(1) : timer_q;
  always_ff @(posedge clk) timer_q <= !rst_n ? '0 : timer_d;
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif
  always_ff @(posedge clk) state_q <= !rst_n ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = cmd_write ? WR : RD_A;
      WR:      if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_B;
      WR_B:    if (b_hs) state_d = RSP;
      RD_A:    if (m_arready) state_d = RD_R;
      RD_R:    if (r_hs) state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = RSP;
  end
  always_comb begin
    addr_d    = accept ? cmd_addr : addr_q;
    wdata_d   = accept ? cmd_wdata : wdata_q;
    wstrb_d   = accept ? cmd_wstrb : wstrb_q;
    aw_done_d = (state_q == WR) & (aw_done_q | aw_hs);
    w_done_d  = (state_q == WR) & (w_done_q | w_hs);
    rdata_d   = timeout ? '0 : r_hs ? m_rdata : b_hs ? '0 : rdata_q;
    resp_d    = timeout ? 2'b10 : r_hs ? m_rresp : b_hs ? m_bresp : resp_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end
  always_comb begin
    cmd_ready = rst_n & (state_q == IDLE);
    m_awvalid = (state_q == WR) & ~aw_done_q;
    m_wvalid  = (state_q == WR) & ~w_done_q;
    m_bready  = state_q == WR_B;
    m_arvalid = state_q == RD_A;
    m_rready  = state_q == RD_R;
    rsp_valid = state_q == RSP;
    rsp_rdata = rdata_q;
    rsp_resp  = resp_q;
    m_awaddr  = addr_q;
    m_araddr  = addr_q;
    m_wdata   = wdata_q;
    m_wstrb   = wstrb_q;
    m_awprot  = 3'b000;
    m_arprot  = 3'b000;
  end
endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb_axi_lite_cfg_master: directed stimulus, scoreboard queue checked by a response monitor.
module tb_axi_lite_cfg_master;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;
  logic        aw_ready_en = 1, ar_ready_en = 1, b_hold = 0;
  logic [1:0]  slv_bresp = 0, slv_rresp = 0;
  logic        got_aw, got_w;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] mem [16];
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  int cyc = 0, accept_cyc = 0, last_rsp_cyc = 0, viol = 0;
  int n_tests = 0, n_fail = 0;
  logic prev_rsp = 0;
  logic [33:0] exp_q[$];

  axi_lite_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_awready = aw_ready_en;
  assign m_wready  = 1'b1;
  assign m_arready = ar_ready_en;
  assign m_bresp   = slv_bresp;
  assign m_rresp   = slv_rresp;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  // Zero-wait register slave; B/R follow one cycle after the address/data handshakes.
  always @(posedge clk) begin
    logic [31:0] a, d, o;
    logic [3:0]  s;
    if (!rst_n) begin
      got_aw <= 0; got_w <= 0; m_bvalid <= 0; m_rvalid <= 0; m_rdata <= 0;
    end else begin
      a = (m_awvalid && m_awready) ? m_awaddr : aw_addr_s;
      d = (m_wvalid && m_wready) ? m_wdata : w_data_s;
      s = (m_wvalid && m_wready) ? m_wstrb : w_strb_s;
      if (m_awvalid && m_awready) begin got_aw <= 1; aw_addr_s <= m_awaddr; aw_cnt <= aw_cnt + 1; end
      if (m_wvalid && m_wready) begin got_w <= 1; w_data_s <= m_wdata; w_strb_s <= m_wstrb; w_cnt <= w_cnt + 1; end
      if (m_bvalid && m_bready) begin m_bvalid <= 0; b_cnt <= b_cnt + 1; end
      if ((got_aw || (m_awvalid && m_awready)) && (got_w || (m_wvalid && m_wready)) && !m_bvalid && !b_hold) begin
        o = mem[a[5:2]];
        for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
        mem[a[5:2]] <= o;
        m_bvalid <= 1; got_aw <= 0; got_w <= 0;
      end
      if (m_rvalid && m_rready) m_rvalid <= 0;
      if (m_arvalid && m_arready) begin m_rvalid <= 1; m_rdata <= mem[m_araddr[5:2]]; ar_cnt <= ar_cnt + 1; end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    logic [33:0] e;
    if (rsp_valid) begin
      last_rsp_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_rsp: got %h/%b expected none", rsp_rdata, rsp_resp);
      end else begin
        e = exp_q.pop_front();
        check("rsp", {30'd0, rsp_rdata, rsp_resp}, {30'd0, e});
      end
    end
    if (cmd_ready && (m_awvalid | m_wvalid | m_bready | m_arvalid | m_rready | rsp_valid)) viol++;
    if (rsp_valid && prev_rsp) viol++;
    prev_rsp = rsp_valid;
  end

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [33:0] exp, input bit push);
    int k = 0;
    if (push) exp_q.push_back(exp);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept: got no cmd_ready expected within 100 cycles");
    end
    accept_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, {57'd0, cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 64'd0);
    check({name, "_rsp"}, {30'd0, rsp_rdata, rsp_resp}, 64'd0);
    check({name, "_addr"}, {m_awaddr, m_araddr}, 64'd0);
    check({name, "_wdat"}, {28'd0, m_wstrb, m_wdata}, 64'd0);
  endtask

  initial begin
    int a0, b0, w0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", {63'd0, cmd_ready}, 64'd1);

    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_cmd(1, 32'h04, 32'hDEADBEEF, 4'hF, {32'h0, 2'b00}, 1);
    cmd_valid = 0;
    wait_rsp();
    check("wr_latency", 64'(last_rsp_cyc - accept_cyc), 64'd3);
    check("wr_hs_count", {32'(aw_cnt - a0), 32'(w_cnt - w0)}, {32'd1, 32'd1});

    a0 = ar_cnt;
    do_cmd(0, 32'h04, 32'h0, 4'h0, {32'hDEADBEEF, 2'b00}, 1);
    cmd_valid = 0;
    wait_rsp();
    check("rd_latency", 64'(last_rsp_cyc - accept_cyc), 64'd3);
    check("rd_hs_count", 64'(ar_cnt - a0), 64'd1);

    b0 = b_cnt; w0 = w_cnt;
    aw_ready_en = 0;
    do_cmd(1, 32'h0C, 32'h12345678, 4'hF, {32'h0, 2'b00}, 1);
    cmd_valid = 0;
    check("aw_w_start", {62'd0, m_awvalid, m_wvalid}, 64'b11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("aw_hold", {m_awaddr, 29'd0, m_awvalid, m_wvalid, rsp_valid}, {32'h0C, 29'd0, 3'b100});
    end
    aw_ready_en = 1;
    wait_rsp();
    check("aw_late_counts", {32'(b_cnt - b0), 32'(w_cnt - w0)}, {32'd1, 32'd1});

    do_cmd(1, 32'h10, 32'h000000A5, 4'hF, {32'h0, 2'b00}, 1);
    a0 = accept_cyc;
    do_cmd(0, 32'h10, 32'h0, 4'h0, {32'h000000A5, 2'b00}, 1);
    check("b2b_spacing", 64'(accept_cyc - a0), 64'd4);
    do_cmd(1, 32'h0C, 32'hAABBCCDD, 4'h5, {32'h0, 2'b00}, 1);
    do_cmd(0, 32'h0C, 32'h0, 4'h0, {32'h12BB56DD, 2'b00}, 1);
    cmd_valid = 0;
    wait_rsp();

    slv_bresp = 2'b10;
    do_cmd(1, 32'h14, 32'h11110000, 4'hF, {32'h0, 2'b10}, 1);
    cmd_valid = 0;
    wait_rsp();
    slv_bresp = 2'b00; slv_rresp = 2'b11;
    do_cmd(0, 32'h14, 32'h0, 4'h0, {32'h11110000, 2'b11}, 1);
    cmd_valid = 0;
    wait_rsp();
    slv_rresp = 2'b00;

    b_hold = 1;
    do_cmd(1, 32'h08, 32'h55555555, 4'hF, 34'd0, 0);
    cmd_valid = 0;
    for (int k = 0; k < 20 && !m_bready; k++) @(negedge clk);
    check("in_wr_b", {63'd0, m_bready}, 64'd1);
    rst_n = 0;
    @(negedge clk);
    check_quiet("mid_reset");
    b_hold = 0;
    rst_n = 1;
    @(negedge clk);
    do_cmd(1, 32'h08, 32'hCAFEF00D, 4'hF, {32'h0, 2'b00}, 1);
    cmd_valid = 0;
    wait_rsp();
    do_cmd(0, 32'h08, 32'h0, 4'h0, {32'hCAFEF00D, 2'b00}, 1);
    cmd_valid = 0;
    wait_rsp();

`ifdef AXI_TIMEOUT_EN
    ar_ready_en = 0;
    do_cmd(0, 32'h04, 32'h0, 4'h0, {32'h0, 2'b10}, 1);
    cmd_valid = 0;
    wait_rsp();
    check("to_latency", 64'(last_rsp_cyc - accept_cyc), 64'd16);
    check("to_arvalid", {63'd0, m_arvalid}, 64'd0);
    ar_ready_en = 1;
`endif

    check("ready_only_idle", 64'(viol), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end
endmodule
